wb_arbiter_stage: RTL
=====================

// Module: wb_arbiter_stage
// PURPOSE
//  Write-back stage directly upstream of register_file: merges ALU results and load/NIC return
//  data onto the RF's single write port (we/sel/addr_wr/data_in), one write per cycle.
//  Keeps a per-register pending-load scoreboard so decode can stall on load-use hazards.
//  Output write fields are registered; relies on RF internal forwarding for same-cycle read-after-write.
// PARAMETERS
//  ADDR_WIDTH  5   register address width (2**ADDR_WIDTH registers)
//  DATA_WIDTH  64  register data width
//  SEL_WIDTH   3   ppp field width
// PORTS
//  clk            in   1           single clock, rising edge
//  reset          in   1           synchronous, active-high
//  alu_valid      in   1           ALU result present
//  alu_ready      out  1           ALU result accepted this cycle
//  alu_addr       in   ADDR_WIDTH  destination register
//  alu_sel        in   SEL_WIDTH   ppp field
//  alu_data       in   [0:DATA_WIDTH-1] result
//  ld_valid       in   1           load return present
//  ld_ready       out  1           load return accepted this cycle
//  ld_addr/ld_sel/ld_data  in  ADDR_WIDTH/SEL_WIDTH/DATA_WIDTH  as alu_*
//  ld_issue       in   1           decode issued a load; marks ld_issue_addr pending
//  ld_issue_addr  in   ADDR_WIDTH  destination of issued load
//  rf_we          out  1           to register_file.we
//  rf_sel         out  SEL_WIDTH   to register_file.sel
//  rf_addr_wr     out  ADDR_WIDTH  to register_file.addr_wr
//  rf_data_in     out  [0:DATA_WIDTH-1] to register_file.data_in
//  reg_busy       out  [0:2**ADDR_WIDTH-1] bit i = load outstanding on register i
//  err_sel        out  1           one-cycle pulse: accepted write had illegal ppp
// BEHAVIOUR
//  - Reset: rf_we=0, rf_sel=0, rf_addr_wr=0, rf_data_in=0, reg_busy=0, err_sel=0, rr_ptr=ALU.
//    Reset asserted mid-operation discards any captured write (rf_we=0 next cycle), clears all busy bits.
//  - Handshake: a source transfers on the edge where valid&&ready. ready is combinational from
//    both valids and rr_ptr; never asserted while reset is high. Source must hold fields while valid&&!ready.
//  - Arbitration: only one valid -> it is granted. Both valid -> grant source named by rr_ptr;
//    rr_ptr then flips to the other source. rr_ptr only changes on a contended grant.
//  - Latency: transfer at edge N -> rf_we/rf_sel/rf_addr_wr/rf_data_in valid cycle N..N+1,
//    RF writes at edge N+1. No grant -> rf_we=0 next cycle (other rf_* hold last values).
//  - ppp legal codes 000 all,001 upper32,010 lower32,011 even bytes,100 odd bytes; passed
//    unchanged. Codes 101-111: transfer still accepted (source not stalled), rf_we=0,
//    err_sel=1 for one cycle; scoreboard still cleared for a load return.
//  - Register 0 is an ordinary writable register; no special-casing.
//  - Scoreboard: ld_issue sets reg_busy[ld_issue_addr] at the edge. Accepted load return
//    clears reg_busy[ld_addr] at the transfer edge (decode then reads via RF forwarding).
//    Same edge set and clear on same register -> set wins. Set on already-busy register: stays 1.
//    ALU writes never touch reg_busy.
// TESTING
//  1 reset high 2 cycles, then idle -> all outputs 0, reg_busy all 0, alu_ready=ld_ready=0 during reset.
//  2 alu_valid, addr=5, sel=000, data=64'hDEAD_BEEF_0123_4567 -> alu_ready=1 same cycle; next
//    cycle rf_we=1, rf_addr_wr=5, same data; RF read of $5 afterwards returns it.
//  3 both valid 4 consecutive cycles (alu addr 1, ld addr 2) -> grants ALU,LD,ALU,LD;
//    rf_addr_wr sequence 1,2,1,2 one cycle later; loser's ready=0 in each cycle.
//  4 ld_issue addr 7 -> reg_busy[7]=1; ld return addr 7 accepted -> reg_busy[7]=0 same edge;
//    ld_issue addr 7 on same edge as return to 7 -> reg_busy[7] stays 1.
//  5 alu write sel=101 -> alu_ready=1, rf_we=0, err_sel pulses once; sel=011 data
//    64'h1111_1111_1111_1111 -> rf_sel=011 passed through, only even bytes change in RF.
//  6 reset asserted in the cycle after a transfer with busy bits set -> rf_we=0, reg_busy=0 next cycle.

Source files
------------

// File: rtl/wb_arbiter_stage.sv
// Write-back stage: round-robin merge of ALU results and load returns onto the register
// file's single write port, plus a per-register pending-load scoreboard for decode stalls.
module wb_arbiter_stage #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDR_WIDTH-1:0]    alu_addr,
    input  logic [SEL_WIDTH-1:0]     alu_sel,
    input  logic [0:DATA_WIDTH-1]    alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDR_WIDTH-1:0]    ld_addr,
    input  logic [SEL_WIDTH-1:0]     ld_sel,
    input  logic [0:DATA_WIDTH-1]    ld_data,
    input  logic                     ld_issue,
    input  logic [ADDR_WIDTH-1:0]    ld_issue_addr,
    output logic                     rf_we,
    output logic [SEL_WIDTH-1:0]     rf_sel,
    output logic [ADDR_WIDTH-1:0]    rf_addr_wr,
    output logic [0:DATA_WIDTH-1]    rf_data_in,
    output logic [0:2**ADDR_WIDTH-1] reg_busy,
    output logic                     err_sel
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LD  = 1'b1
    } src_e;

    // Legal ppp codes are 000..100; anything above is rejected at the write port.
    function automatic logic sel_legal(input logic [SEL_WIDTH-1:0] sel);
        return (sel <= SEL_WIDTH'(4));
    endfunction

    src_e                    rr_ptr_r;
    src_e                    rr_ptr_next_s;
    logic                    grant_alu_s;
    logic                    grant_ld_s;
    logic                    wr_any_s;
    logic [SEL_WIDTH-1:0]    win_sel_s;
    logic [ADDR_WIDTH-1:0]   win_addr_s;
    logic [0:DATA_WIDTH-1]   win_data_s;
    logic                    win_legal_s;
    logic [0:NUM_REGS-1]     busy_next_s;

    logic                    rf_we_r;
    logic [SEL_WIDTH-1:0]    rf_sel_r;
    logic [ADDR_WIDTH-1:0]   rf_addr_wr_r;
    logic [0:DATA_WIDTH-1]   rf_data_in_r;
    logic [0:NUM_REGS-1]     reg_busy_r;
    logic                    err_sel_r;

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r <= SRC_ALU;
        end else begin
            rr_ptr_r <= rr_ptr_next_s;
        end
    end

    // Pointer moves to the other source only after a contended grant.
    always_comb begin
        rr_ptr_next_s = rr_ptr_r;
        if (alu_valid && ld_valid && !reset) begin
            case (rr_ptr_r)
                SRC_ALU: rr_ptr_next_s = SRC_LD;
                SRC_LD:  rr_ptr_next_s = SRC_ALU;
                default: rr_ptr_next_s = SRC_ALU;
            endcase
        end else begin
            rr_ptr_next_s = rr_ptr_r;
        end
    end

    // Grant decode: a lone requester always wins, contention goes to rr_ptr.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_ld_s  = 1'b0;
        if (reset) begin
            grant_alu_s = 1'b0;
            grant_ld_s  = 1'b0;
        end else begin
            grant_alu_s = alu_valid && (!ld_valid || (rr_ptr_r == SRC_ALU));
            grant_ld_s  = ld_valid && (!alu_valid || (rr_ptr_r == SRC_LD));
        end
    end

    assign alu_ready = grant_alu_s;
    assign ld_ready  = grant_ld_s;
    assign wr_any_s  = grant_alu_s | grant_ld_s;

    // Winning source's write fields.
    always_comb begin
        win_sel_s  = alu_sel;
        win_addr_s = alu_addr;
        win_data_s = alu_data;
        if (grant_ld_s) begin
            win_sel_s  = ld_sel;
            win_addr_s = ld_addr;
            win_data_s = ld_data;
        end else begin
            win_sel_s  = alu_sel;
            win_addr_s = alu_addr;
            win_data_s = alu_data;
        end
    end

    assign win_legal_s = sel_legal(win_sel_s);

    // Scoreboard next state: a new issue beats a same-edge return to the same register.
    always_comb begin
        busy_next_s = reg_busy_r;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_next_s[i] = (ld_issue && (ld_issue_addr == ADDR_WIDTH'(i))) ? 1'b1 :
                             (grant_ld_s && (ld_addr == ADDR_WIDTH'(i)))     ? 1'b0 :
                             reg_busy_r[i];
        end
    end

    // Registered write port; illegal ppp still consumes the transfer but suppresses the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we_r      <= 1'b0;
            rf_sel_r     <= '0;
            rf_addr_wr_r <= '0;
            rf_data_in_r <= '0;
            err_sel_r    <= 1'b0;
        end else if (wr_any_s) begin
            rf_we_r      <= win_legal_s;
            err_sel_r    <= !win_legal_s;
            rf_sel_r     <= win_sel_s;
            rf_addr_wr_r <= win_addr_s;
            rf_data_in_r <= win_data_s;
        end else begin
            rf_we_r      <= 1'b0;
            err_sel_r    <= 1'b0;
        end
    end

    // Pending-load scoreboard register.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_busy_r <= '0;
        end else begin
            reg_busy_r <= busy_next_s;
        end
    end

    assign rf_we      = rf_we_r;
    assign rf_sel     = rf_sel_r;
    assign rf_addr_wr = rf_addr_wr_r;
    assign rf_data_in = rf_data_in_r;
    assign reg_busy   = reg_busy_r;
    assign err_sel    = err_sel_r;

endmodule
